// File: rtl/strobe_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : strobe_gen_multi
// Description : Multi-channel runtime-programmable strobe generator. Each
//               channel emits a one-cycle tick every div enabled clocks.
//               Optional 50% duty square output is enabled by defining the
//               macro STROBE_SQUARE_EN; otherwise square is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_gen_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] load,
    input  logic [WIDTH-1:0]    load_div,
    input  logic                sync_all,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] square
);

    localparam logic [WIDTH-1:0] c_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_ONE         = WIDTH'(1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_cnt;
        logic             r_strobe;
        logic [WIDTH-1:0] w_div_nxt;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic             w_strobe_nxt;

        // Terminal compare only reached when div is non-zero, so div-1 never wraps.
        always_comb begin
            w_div_nxt    = r_div;
            w_cnt_nxt    = r_cnt;
            w_strobe_nxt = 1'b0;
            if (load[g]) begin
                w_div_nxt = load_div;
                w_cnt_nxt = '0;
            end else if (sync_all) begin
                w_cnt_nxt = '0;
            end else if (r_div == '0) begin
                w_cnt_nxt = '0;
            end else if (enable[g]) begin
                if (r_cnt == (r_div - c_ONE)) begin
                    w_cnt_nxt    = '0;
                    w_strobe_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_div    <= c_DEFAULT_DIV;
                r_cnt    <= '0;
                r_strobe <= 1'b0;
            end else begin
                r_div    <= w_div_nxt;
                r_cnt    <= w_cnt_nxt;
                r_strobe <= w_strobe_nxt;
            end
        end

        assign strobe[g] = r_strobe;

`ifdef STROBE_SQUARE_EN
        logic r_square;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_square <= 1'b0;
            end else if (w_strobe_nxt) begin
                r_square <= ~r_square;
            end
        end

        assign square[g] = r_square;
`else
        assign square[g] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_strobe_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_strobe_gen_multi
// Description : Scoreboard bench for strobe_gen_multi; directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_gen_multi;

    localparam int c_CH  = 4;
    localparam int c_W   = 16;
    localparam int c_DEF = 8;

    logic            clk;
    logic            rst;
    logic [c_CH-1:0] enable;
    logic [c_CH-1:0] load;
    logic [c_W-1:0]  load_div;
    logic            sync_all;
    logic [c_CH-1:0] strobe;
    logic [c_CH-1:0] square;

    strobe_gen_multi #(
        .CHANNELS    (c_CH),
        .WIDTH       (c_W),
        .DEFAULT_DIV (c_DEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .load     (load),
        .load_div (load_div),
        .sync_all (sync_all),
        .strobe   (strobe),
        .square   (square)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase = enabled cycles since the last restart; a tick every div of them.
    int          m_div   [c_CH];
    int          m_phase [c_CH];
    bit          m_sq    [c_CH];
    logic [2*c_CH-1:0] exp_q[$];

    int vectors;
    int miscompares;
    int cycle_no;

    task automatic cyc(input bit r, input logic [c_CH-1:0] en,
                       input logic [c_CH-1:0] ld, input int ldv, input bit sy);
        logic [c_CH-1:0] s;
        logic [c_CH-1:0] q;
        @(negedge clk);
        rst      = r;
        enable   = en;
        load     = ld;
        load_div = c_W'(ldv);
        sync_all = sy;
        s = '0;
        for (int i = 0; i < c_CH; i++) begin
            if (r) begin
                m_div[i]   = c_DEF;
                m_phase[i] = 0;
                m_sq[i]    = 1'b0;
            end else if (ld[i]) begin
                m_div[i]   = ldv;
                m_phase[i] = 0;
            end else if (sy || m_div[i] == 0) begin
                m_phase[i] = 0;
            end else if (en[i]) begin
                m_phase[i] = m_phase[i] + 1;
                if (m_phase[i] % m_div[i] == 0) begin
                    s[i]       = 1'b1;
                    m_phase[i] = 0;
                end
            end
`ifdef STROBE_SQUARE_EN
            if (s[i]) m_sq[i] = ~m_sq[i];
`endif
            q[i] = m_sq[i];
        end
        exp_q.push_back({s, q});
    endtask

    task automatic run(input int n, input logic [c_CH-1:0] en);
        for (int k = 0; k < n; k++) cyc(1'b0, en, '0, 0, 1'b0);
    endtask

    // Monitor: one registered output per clock, compared against the queue head.
    initial begin
        logic [2*c_CH-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({strobe, square} !== e) begin
                    miscompares++;
                    $display("FAIL out@cycle%0d strobe/square got %b/%b want %b/%b",
                             cycle_no, strobe, square, e[2*c_CH-1:c_CH], e[c_CH-1:0]);
                end
                cycle_no++;
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle_no    = 0;
        rst = 1'b1; enable = '0; load = '0; load_div = '0; sync_all = 1'b0;
        for (int i = 0; i < c_CH; i++) begin
            m_div[i] = c_DEF; m_phase[i] = 0; m_sq[i] = 1'b0;
        end

        // Reset, then channel 0 alone at the default divisor.
        cyc(1'b1, 4'b0000, '0, 0, 1'b0);
        cyc(1'b1, 4'b1111, 4'b1111, 3, 1'b1);
        run(20, 4'b0001);

        // Channel 1 at div 3, then div 1.
        cyc(1'b0, 4'b0010, 4'b0010, 3, 1'b0);
        run(10, 4'b0010);
        cyc(1'b0, 4'b0010, 4'b0010, 1, 1'b0);
        run(5, 4'b0010);

        // Enable gap mid-period on channel 0.
        cyc(1'b0, 4'b0001, 4'b0001, 8, 1'b0);
        run(12, 4'b0001);
        run(5, 4'b0000);
        run(10, 4'b0001);

        // Two channels phase-aligned by sync_all.
        cyc(1'b0, 4'b0011, 4'b0001, 5, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0010, 7, 1'b0);
        run(9, 4'b0011);
        cyc(1'b0, 4'b0011, '0, 0, 1'b1);
        run(40, 4'b0011);

        // Stalled divisor, then reset mid-count.
        cyc(1'b0, 4'b1111, 4'b1111, 0, 1'b0);
        run(10, 4'b1111);
        cyc(1'b0, 4'b1111, 4'b1111, 6, 1'b0);
        run(4, 4'b1111);
        cyc(1'b1, 4'b1111, '0, 0, 1'b0);
        run(10, 4'b1111);

        // Square output at div 4.
        cyc(1'b0, 4'b0001, 4'b0001, 4, 1'b0);
        run(20, 4'b0001);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bit              r;
            bit              sy;
            logic [c_CH-1:0] en;
            logic [c_CH-1:0] ld;
            int              ldv;
            r  = ($urandom_range(0, 199) == 0);
            sy = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < c_CH; i++) begin
                en[i] = ($urandom_range(0, 9) < 8);
                ld[i] = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 7) == 0) ldv = int'($urandom_range(0, 65535));
            else                           ldv = int'($urandom_range(0, 12));
            cyc(r, en, ld, ldv, sy);
        end

        run(2, '0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
